id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 55 +++++
 rtl/id_ex_stage_load_use_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline types for the ID/EX boundary.
// Used by the decoder, the ID/EX register and the forwarding logic.
package id_ex_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned ALU_OP_W  = 4;
    localparam int unsigned CNT_W     = 16;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA,
        ALU_PASS = 4'hB
    } alu_op_e;

    // Control bundle, MSB first: regWrite .. jump, then aluOp.
    typedef struct packed {
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                to_reg;
        logic                alu_src;
        logic                branch;
        logic                jump;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // Register-file read value with same-cycle WB write-through; x0 never bypassed.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic            wb_rw,
        input reg_idx_t        wb_rd,
        input logic [XLEN-1:0] wb_data,
        input reg_idx_t        rs,
        input logic [XLEN-1:0] rf_data
    );
        if (wb_rw && (wb_rd != '0) && (wb_rd == rs)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination
// is read by the valid instruction currently in ID.
module load_use_detect
    import id_ex_stage_pkg::*;
(
    input  logic     ex_valid,
    input  logic     ex_mem_read,
    input  reg_idx_t ex_rd,
    input  logic     id_valid,
    input  logic     id_use_rs1,
    input  logic     id_use_rs2,
    input  reg_idx_t id_rs1,
    input  reg_idx_t id_rs2,
    output logic     ld_use_c
);

    logic rs1_hit_c;
    logic rs2_hit_c;

    assign rs1_hit_c = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit_c = id_use_rs2 && (id_rs2 == ex_rd);

    assign ld_use_c = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid
                      && (rs1_hit_c || rs2_hit_c);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB write-through bypass, load-use bubble
// insertion and a count of load-use bubbles.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,

    input  logic                id_valid,
    input  logic [XLEN-1:0]     id_pc,
    input  reg_idx_t            id_rs1,
    input  reg_idx_t            id_rs2,
    input  reg_idx_t            id_rd,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [XLEN-1:0]     id_regRData1,
    input  logic [XLEN-1:0]     id_regRData2,
    input  logic [XLEN-1:0]     id_imm,

    input  logic                id_regWrite,
    input  logic                id_memRead,
    input  logic                id_memWrite,
    input  logic                id_toReg,
    input  logic                id_aluSrc,
    input  logic                id_branch,
    input  logic                id_jump,
    input  logic [ALU_OP_W-1:0] id_aluOp,

    input  logic                wb_rw,
    input  reg_idx_t            wb_rd,
    input  logic [XLEN-1:0]     wb_data,

    input  logic                ex_flush,
    input  logic                mem_stall,

    output logic                id_ex_valid,
    output logic [XLEN-1:0]     id_ex_pc,
    output reg_idx_t            id_ex_rs1,
    output reg_idx_t            id_ex_rs2,
    output reg_idx_t            id_ex_rd,
    output logic [XLEN-1:0]     id_ex_data_regRData1,
    output logic [XLEN-1:0]     id_ex_data_regRData2,
    output logic [XLEN-1:0]     id_ex_imm,
    output logic                id_ex_regWrite,
    output logic                id_ex_memRead,
    output logic                id_ex_memWrite,
    output logic                id_ex_toReg,
    output logic                id_ex_aluSrc,
    output logic                id_ex_branch,
    output logic                id_ex_jump,
    output logic [ALU_OP_W-1:0] id_ex_aluOp,

    output logic                ld_use_stall,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic              valid_q,  valid_d;
    logic [XLEN-1:0]   pc_q,     pc_d;
    reg_idx_t          rs1_q,    rs1_d;
    reg_idx_t          rs2_q,    rs2_d;
    reg_idx_t          rd_q,     rd_d;
    logic [XLEN-1:0]   rdata1_q, rdata1_d;
    logic [XLEN-1:0]   rdata2_q, rdata2_d;
    logic [XLEN-1:0]   imm_q,    imm_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    ctrl_t id_ctrl_c;
    ctrl_t ex_ctrl_c;
    logic  ld_use_c;

    assign id_ctrl_c = '{
        reg_write: id_regWrite,
        mem_read:  id_memRead,
        mem_write: id_memWrite,
        to_reg:    id_toReg,
        alu_src:   id_aluSrc,
        branch:    id_branch,
        jump:      id_jump,
        alu_op:    id_aluOp
    };
    assign ex_ctrl_c = ctrl_t'(ctrl_q);

    load_use_detect u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ex_ctrl_c.mem_read),
        .ex_rd       (rd_q),
        .id_valid    (id_valid),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ld_use_c    (ld_use_c)
    );

    // Next-state: freeze > flush bubble > load-use bubble > normal capture.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        rdata1_d     = rdata1_q;
        rdata2_d     = rdata2_q;
        imm_d        = imm_q;
        ctrl_d       = ctrl_q;
        bubble_cnt_d = bubble_cnt_q;

        if (!mem_stall) begin
            if (ex_flush || ld_use_c) begin
                valid_d  = 1'b0;
                pc_d     = '0;
                rs1_d    = '0;
                rs2_d    = '0;
                rd_d     = '0;
                rdata1_d = '0;
                rdata2_d = '0;
                imm_d    = '0;
                ctrl_d   = '0;
                // A flush already kills the pair, so it is not a load-use bubble.
                if (!ex_flush) begin
                    bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
                end
            end else begin
                valid_d  = id_valid;
                pc_d     = id_pc;
                rs1_d    = id_rs1;
                rs2_d    = id_rs2;
                rd_d     = id_rd;
                rdata1_d = wb_bypass(wb_rw, wb_rd, wb_data, id_rs1, id_regRData1);
                rdata2_d = wb_bypass(wb_rw, wb_rd, wb_data, id_rs2, id_regRData2);
                imm_d    = id_imm;
                ctrl_d   = id_valid ? CTRL_W'(id_ctrl_c) : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            imm_q        <= '0;
            ctrl_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            rdata1_q     <= rdata1_d;
            rdata2_q     <= rdata2_d;
            imm_q        <= imm_d;
            ctrl_q       <= ctrl_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign id_ex_valid          = valid_q;
    assign id_ex_pc             = pc_q;
    assign id_ex_rs1            = rs1_q;
    assign id_ex_rs2            = rs2_q;
    assign id_ex_rd             = rd_q;
    assign id_ex_data_regRData1 = rdata1_q;
    assign id_ex_data_regRData2 = rdata2_q;
    assign id_ex_imm            = imm_q;
    assign id_ex_regWrite       = ex_ctrl_c.reg_write;
    assign id_ex_memRead        = ex_ctrl_c.mem_read;
    assign id_ex_memWrite       = ex_ctrl_c.mem_write;
    assign id_ex_toReg          = ex_ctrl_c.to_reg;
    assign id_ex_aluSrc         = ex_ctrl_c.alu_src;
    assign id_ex_branch         = ex_ctrl_c.branch;
    assign id_ex_jump           = ex_ctrl_c.jump;
    assign id_ex_aluOp          = ex_ctrl_c.alu_op;
    assign ld_use_stall         = ld_use_c;
    assign bubble_cnt           = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a cycle model of the ID/EX boundary checked
// on every falling edge, plus hand-computed literal checks per scenario.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_regRData1, id_regRData2, id_imm;
    logic        id_regWrite, id_memRead, id_memWrite, id_toReg;
    logic        id_aluSrc, id_branch, id_jump;
    logic [3:0]  id_aluOp;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_flush, mem_stall;

    logic        id_ex_valid;
    logic [31:0] id_ex_pc;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic [31:0] id_ex_data_regRData1, id_ex_data_regRData2, id_ex_imm;
    logic        id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_toReg;
    logic        id_ex_aluSrc, id_ex_branch, id_ex_jump;
    logic [3:0]  id_ex_aluOp;
    logic        ld_use_stall;
    logic [15:0] bubble_cnt;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b1;

    // Control words: {regWrite, memRead, memWrite, toReg, aluSrc, branch, jump, aluOp}
    localparam logic [10:0] C_LW  = 11'b1_1_0_1_1_0_0_0000;
    localparam logic [10:0] C_ADD = 11'b1_0_0_0_0_0_0_0000;
    localparam logic [10:0] C_BEQ = 11'b0_0_0_0_0_1_0_0001;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_regRData1(id_regRData1), .id_regRData2(id_regRData2), .id_imm(id_imm),
        .id_regWrite(id_regWrite), .id_memRead(id_memRead), .id_memWrite(id_memWrite),
        .id_toReg(id_toReg), .id_aluSrc(id_aluSrc), .id_branch(id_branch),
        .id_jump(id_jump), .id_aluOp(id_aluOp),
        .wb_rw(wb_rw), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_flush(ex_flush), .mem_stall(mem_stall),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1(id_ex_rs1),
        .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .id_ex_data_regRData1(id_ex_data_regRData1),
        .id_ex_data_regRData2(id_ex_data_regRData2), .id_ex_imm(id_ex_imm),
        .id_ex_regWrite(id_ex_regWrite), .id_ex_memRead(id_ex_memRead),
        .id_ex_memWrite(id_ex_memWrite), .id_ex_toReg(id_ex_toReg),
        .id_ex_aluSrc(id_ex_aluSrc), .id_ex_branch(id_ex_branch),
        .id_ex_jump(id_ex_jump), .id_ex_aluOp(id_ex_aluOp),
        .ld_use_stall(ld_use_stall), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_valid;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [10:0] m_ctrl;
    logic [15:0] m_cnt;
    logic        m_stall;
    logic [10:0] id_ctrl, dut_ctrl;

    assign id_ctrl  = {id_regWrite, id_memRead, id_memWrite, id_toReg, id_aluSrc,
                       id_branch, id_jump, id_aluOp};
    assign dut_ctrl = {id_ex_regWrite, id_ex_memRead, id_ex_memWrite, id_ex_toReg,
                       id_ex_aluSrc, id_ex_branch, id_ex_jump, id_ex_aluOp};

    // Hazard: the instruction in EX is a load whose nonzero rd is read by ID.
    assign m_stall = m_valid && m_ctrl[9] && (m_rd != 5'd0) && id_valid &&
                     ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));

    function automatic logic [31:0] rf_read(input logic [4:0] rs, input logic [31:0] rf);
        return (wb_rw && wb_rd != 5'd0 && wb_rd == rs) ? wb_data : rf;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_pc <= '0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0;
            m_d1 <= '0; m_d2 <= '0; m_imm <= '0; m_ctrl <= '0; m_cnt <= '0;
        end else if (mem_stall) begin
            m_cnt <= m_cnt;
        end else if (ex_flush || m_stall) begin
            m_valid <= 1'b0; m_pc <= '0; m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0;
            m_d1 <= '0; m_d2 <= '0; m_imm <= '0; m_ctrl <= '0;
            m_cnt <= ex_flush ? m_cnt : 16'(m_cnt + 16'd1);
        end else begin
            m_valid <= id_valid; m_pc <= id_pc; m_rs1 <= id_rs1; m_rs2 <= id_rs2;
            m_rd <= id_rd; m_imm <= id_imm;
            m_d1 <= rf_read(id_rs1, id_regRData1);
            m_d2 <= rf_read(id_rs2, id_regRData2);
            m_ctrl <= id_valid ? id_ctrl : 11'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m.valid", 32'(id_ex_valid), 32'(m_valid));
            chk("m.pc", id_ex_pc, m_pc);
            chk("m.rs1", 32'(id_ex_rs1), 32'(m_rs1));
            chk("m.rs2", 32'(id_ex_rs2), 32'(m_rs2));
            chk("m.rd", 32'(id_ex_rd), 32'(m_rd));
            chk("m.rdata1", id_ex_data_regRData1, m_d1);
            chk("m.rdata2", id_ex_data_regRData2, m_d2);
            chk("m.imm", id_ex_imm, m_imm);
            chk("m.ctrl", 32'(dut_ctrl), 32'(m_ctrl));
            chk("m.bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
            chk("m.ld_use_stall", 32'(ld_use_stall), 32'(m_stall));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                         input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [10:0] c);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_regRData1 = d1; id_regRData2 = d2;
        id_imm = imm;
        {id_regWrite, id_memRead, id_memWrite, id_toReg, id_aluSrc,
         id_branch, id_jump, id_aluOp} = c;
    endtask

    initial begin
        rst_n = 1'b0; wb_rw = 1'b0; wb_rd = '0; wb_data = '0;
        ex_flush = 1'b0; mem_stall = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 11'd0);
        step();
        chk("reset valid", 32'(id_ex_valid), 32'd0);
        chk("reset bubble_cnt", 32'(bubble_cnt), 32'd0);
        chk("reset stall", 32'(ld_use_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // lw x5, 8(x1) then dependent add x6, x5, x7
        drive(1'b1, 32'h100, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h10, 32'h0, 32'h8, C_LW);
        step();
        chk("lw rd", 32'(id_ex_rd), 32'd5);
        chk("lw memRead", 32'(id_ex_memRead), 32'd1);
        drive(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 32'h5, 32'h7, 32'h0, C_ADD);
        #1;
        chk("ld-use stall", 32'(ld_use_stall), 32'd1);
        step();
        chk("bubble valid", 32'(id_ex_valid), 32'd0);
        chk("bubble regWrite", 32'(id_ex_regWrite), 32'd0);
        chk("bubble_cnt 1", 32'(bubble_cnt), 32'd1);
        chk("stall cleared", 32'(ld_use_stall), 32'd0);
        step();
        chk("add captured pc", id_ex_pc, 32'h104);
        chk("add captured rd", 32'(id_ex_rd), 32'd6);

        // WB bypass on rs2, then x0 never bypassed, then rs1 bypass
        wb_rw = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        drive(1'b1, 32'h108, 5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 32'h1111, 32'h0, 32'h0, C_ADD);
        step();
        chk("bypass rs2", id_ex_data_regRData2, 32'hDEADBEEF);
        chk("no bypass rs1", id_ex_data_regRData1, 32'h1111);
        wb_rd = 5'd0;
        drive(1'b1, 32'h10C, 5'd9, 5'd0, 5'd4, 1'b1, 1'b1, 32'h1111, 32'h0, 32'h0, C_ADD);
        step();
        chk("x0 not bypassed", id_ex_data_regRData2, 32'h0);
        wb_rd = 5'd9; wb_data = 32'hCAFEF00D;
        drive(1'b1, 32'h110, 5'd9, 5'd2, 5'd4, 1'b1, 1'b1, 32'h1111, 32'h2222, 32'h0, C_ADD);
        step();
        chk("bypass rs1", id_ex_data_regRData1, 32'hCAFEF00D);
        chk("no bypass rs2", id_ex_data_regRData2, 32'h2222);
        wb_rw = 1'b0;

        // invalid ID instruction: controls forced low
        drive(1'b0, 32'h114, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, C_LW);
        step();
        chk("invalid ctrl", 32'(dut_ctrl), 32'd0);
        chk("invalid pc", id_ex_pc, 32'h114);

        // mem_stall freezes everything for 3 cycles
        drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 32'hA, 32'hB, 32'hC, C_BEQ);
        step();
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 5'(i), 5'd2, 5'd9, 1'b1, 1'b0,
                  32'(i), 32'h0, 32'h0, C_LW);
            step();
            chk("stall hold pc", id_ex_pc, 32'h200);
            chk("stall hold branch", 32'(id_ex_branch), 32'd1);
            chk("stall hold cnt", 32'(bubble_cnt), 32'd1);
        end
        mem_stall = 1'b0;
        drive(1'b1, 32'h400, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, C_ADD);
        step();
        chk("after stall pc", id_ex_pc, 32'h400);

        // mem_stall beats a load-use hazard, then ex_flush beats it too
        drive(1'b1, 32'h500, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
        step();
        drive(1'b1, 32'h504, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, C_ADD);
        mem_stall = 1'b1;
        #1;
        chk("stall under mem_stall", 32'(ld_use_stall), 32'd1);
        step();
        chk("mem_stall hold pc", id_ex_pc, 32'h500);
        chk("mem_stall cnt", 32'(bubble_cnt), 32'd1);
        mem_stall = 1'b0;
        ex_flush = 1'b1;
        #1;
        chk("stall with flush", 32'(ld_use_stall), 32'd1);
        step();
        chk("flush valid", 32'(id_ex_valid), 32'd0);
        chk("flush regWrite", 32'(id_ex_regWrite), 32'd0);
        chk("flush cnt unchanged", 32'(bubble_cnt), 32'd1);
        ex_flush = 1'b0;
        step();
        chk("post flush pc", id_ex_pc, 32'h504);

        // lw x5, 0(x5) repeated: one load-use bubble every two cycles
        drive(1'b1, 32'h600, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, C_LW);
        cmp_en = 1'b0;
        for (int i = 0; i < 2 * 65534; i++) begin
            step();
        end
        chk("cnt at FFFF", 32'(bubble_cnt), 32'h0000FFFF);
        cmp_en = 1'b1;
        step();
        step();
        chk("cnt wrapped", 32'(bubble_cnt), 32'h0);
        step();
        chk("lw in EX", 32'(id_ex_memRead), 32'd1);

        // asynchronous reset mid-cycle
        #1;
        rst_n = 1'b0;
        #1;
        chk("async rst valid", 32'(id_ex_valid), 32'd0);
        chk("async rst pc", id_ex_pc, 32'h0);
        chk("async rst rd", 32'(id_ex_rd), 32'd0);
        chk("async rst ctrl", 32'(dut_ctrl), 32'd0);
        chk("async rst cnt", 32'(bubble_cnt), 32'd0);
        chk("async rst stall", 32'(ld_use_stall), 32'd0);
        drive(1'b1, 32'h700, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 32'h3, 32'h4, 32'h0, C_ADD);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post reset valid", 32'(id_ex_valid), 32'd1);
        chk("post reset pc", id_ex_pc, 32'h700);
        chk("post reset cnt", 32'(bubble_cnt), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
